// File: rtl/tlb_assoc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tlb_assoc_pkg                                                  |
// | Purpose  : Shared default widths and the miss/flush FSM state encoding    |
// |            used by the fully-associative TLB.                             |
// | Contents : c_VPN_W, c_PPN_W, c_OFF_W, c_ASID_W, tlb_state_t                |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package tlb_assoc_pkg;

   localparam int c_VPN_W  = 20;
   localparam int c_PPN_W  = 8;
   localparam int c_OFF_W  = 12;
   localparam int c_ASID_W = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WALK_REQ  = 2'd1,
      WALK_WAIT = 2'd2,
      FLUSH     = 2'd3
   } tlb_state_t;

endpackage
`default_nettype wire

// File: rtl/tlb_victim_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tlb_victim_sel                                                 |
// | Purpose  : Combinational replacement choice. Lowest-index invalid entry   |
// |            wins; if all are valid, the oldest entry wins, with the        |
// |            lowest index breaking ties.                                    |
// | Ports    : valid  [N]          entry valid bits                           |
// |            age    [N][AGE_W]   saturating age per entry                   |
// |            victim [IDX_W]      selected entry index                       |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tlb_victim_sel #(
   parameter int N     = 16,
   parameter int AGE_W = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]            valid,
   input  logic [N-1:0][AGE_W-1:0] age,
   output logic [IDX_W-1:0]        victim
);

   logic             w_found_free;
   logic [IDX_W-1:0] w_free_idx;
   logic [IDX_W-1:0] w_old_idx;
   logic [AGE_W-1:0] w_old_age;

   always_comb begin
      w_found_free = 1'b0;
      w_free_idx   = '0;
      w_old_idx    = '0;
      w_old_age    = '0;
      // Descending scan so the lowest invalid index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            w_found_free = 1'b1;
            w_free_idx   = IDX_W'(i);
         end
      end
      // Strict '>' on an ascending scan keeps the lowest index on equal ages.
      for (int i = 0; i < N; i++) begin
         if (age[i] > w_old_age) begin
            w_old_age = age[i];
            w_old_idx = IDX_W'(i);
         end
      end
      victim = w_found_free ? w_free_idx : w_old_idx;
   end

endmodule
`default_nettype wire

// File: rtl/tlb_assoc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tlb_assoc                                                      |
// | Purpose  : Fully-associative TLB with ASID tags, global pages,            |
// |            saturating-age LRU, built-in page-table-walk miss FSM and      |
// |            sequenced flush (all entries or by ASID).                      |
// | Ports    : clk, rst (async, active low)                                   |
// |            mode, asid, req_valid/req_ready, vaddr    - lookup request     |
// |            resp_valid, paddr, resp_hit, resp_fault   - lookup response    |
// |            ptw_req_valid/ready, ptw_req_vpn          - walk request       |
// |            ptw_resp_valid, _ppn, _global, _fault     - walk result        |
// |            flush_valid/ready, flush_all, flush_asid  - flush request      |
// | Optional : TLB_STATS_EN adds stat_hits / stat_misses (32-bit, wrapping).  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tlb_assoc
   import tlb_assoc_pkg::*;
#(
   parameter int N      = 16,
   parameter int VPN_W  = c_VPN_W,
   parameter int PPN_W  = c_PPN_W,
   parameter int OFF_W  = c_OFF_W,
   parameter int ASID_W = c_ASID_W,
   parameter int AGE_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mode,
   input  logic [ASID_W-1:0]       asid,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [VPN_W+OFF_W-1:0]  vaddr,
   output logic                    resp_valid,
   output logic [PPN_W+OFF_W-1:0]  paddr,
   output logic                    resp_hit,
   output logic                    resp_fault,
   output logic                    ptw_req_valid,
   input  logic                    ptw_req_ready,
   output logic [VPN_W-1:0]        ptw_req_vpn,
   input  logic                    ptw_resp_valid,
   input  logic [PPN_W-1:0]        ptw_resp_ppn,
   input  logic                    ptw_resp_global,
   input  logic                    ptw_resp_fault,
   input  logic                    flush_valid,
   output logic                    flush_ready,
   input  logic                    flush_all,
   input  logic [ASID_W-1:0]       flush_asid
`ifdef TLB_STATS_EN
   ,
   output logic [31:0]             stat_hits,
   output logic [31:0]             stat_misses
`endif
);

   localparam int               c_IDX_W   = $clog2(N);
   localparam logic [AGE_W-1:0] c_AGE_MAX = '1;

   typedef struct packed {
      logic              valid;
      logic              glb;
      logic [ASID_W-1:0] asid;
      logic [VPN_W-1:0]  vpn;
      logic [PPN_W-1:0]  ppn;
      logic [AGE_W-1:0]  age;
   } entry_t;

   entry_t                   r_ent [N];
   tlb_state_t               r_state;
   tlb_state_t               w_state_next;
   logic [c_IDX_W-1:0]       r_flush_idx;
   logic                     r_flush_all;
   logic [ASID_W-1:0]        r_flush_asid;
   logic [VPN_W-1:0]         r_lat_vpn;
   logic [OFF_W-1:0]         r_lat_off;
   logic [ASID_W-1:0]        r_lat_asid;
   logic                     r_resp_valid;
   logic                     r_resp_hit;
   logic                     r_resp_fault;
   logic [PPN_W+OFF_W-1:0]   r_paddr;

   logic [VPN_W-1:0]         w_req_vpn;
   logic [OFF_W-1:0]         w_req_off;
   logic [N-1:0]             w_match;
   logic [N-1:0]             w_valid_vec;
   logic [N-1:0][AGE_W-1:0]  w_age_vec;
   logic                     w_hit;
   logic [c_IDX_W-1:0]       w_hit_idx;
   logic [c_IDX_W-1:0]       w_victim;
   logic                     w_accept;

   assign w_req_vpn = vaddr[VPN_W+OFF_W-1:OFF_W];
   assign w_req_off = vaddr[OFF_W-1:0];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_entry
         assign w_match[gi]     = r_ent[gi].valid && (r_ent[gi].vpn == w_req_vpn) &&
                                  (r_ent[gi].glb || (r_ent[gi].asid == asid));
         assign w_valid_vec[gi] = r_ent[gi].valid;
         assign w_age_vec[gi]   = r_ent[gi].age;
      end
   endgenerate

   assign w_hit = |w_match;

   always_comb begin
      w_hit_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_match[i]) begin
            w_hit_idx = c_IDX_W'(i);
         end
      end
   end

   tlb_victim_sel #(
      .N     (N),
      .AGE_W (AGE_W),
      .IDX_W (c_IDX_W)
   ) u_victim_sel (
      .valid  (w_valid_vec),
      .age    (w_age_vec),
      .victim (w_victim)
   );

   // ------------------------------------------------------------------
   // FSM: state register + next-state / handshake outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      req_ready     = 1'b0;
      flush_ready   = 1'b0;
      ptw_req_valid = 1'b0;
      case (r_state)
         IDLE: begin
            flush_ready = 1'b1;
            // A pending flush wins; the request is refused in the same cycle.
            req_ready   = !flush_valid;
            if (flush_valid) begin
               w_state_next = FLUSH;
            end else if (req_valid && !mode && !w_hit) begin
               w_state_next = WALK_REQ;
            end
         end
         WALK_REQ: begin
            ptw_req_valid = 1'b1;
            if (ptw_req_ready) begin
               w_state_next = WALK_WAIT;
            end
         end
         WALK_WAIT: begin
            if (ptw_resp_valid) begin
               w_state_next = IDLE;
            end
         end
         FLUSH: begin
            if (r_flush_idx == c_IDX_W'(N - 1)) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_accept = req_valid && req_ready;

   // ------------------------------------------------------------------
   // Entry array, latched miss context and registered response
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            r_ent[i] <= '0;
         end
         r_flush_idx  <= '0;
         r_flush_all  <= 1'b0;
         r_flush_asid <= '0;
         r_lat_vpn    <= '0;
         r_lat_off    <= '0;
         r_lat_asid   <= '0;
         r_resp_valid <= 1'b0;
         r_resp_hit   <= 1'b0;
         r_resp_fault <= 1'b0;
         r_paddr      <= '0;
      end else begin
         // Response fields are single-cycle and read as zero when idle.
         r_resp_valid <= 1'b0;
         r_resp_hit   <= 1'b0;
         r_resp_fault <= 1'b0;
         r_paddr      <= '0;
         case (r_state)
            IDLE: begin
               if (flush_valid) begin
                  r_flush_idx  <= '0;
                  r_flush_all  <= flush_all;
                  r_flush_asid <= flush_asid;
               end else if (w_accept) begin
                  if (mode) begin
                     // Supervisor bypass: low VPN bits pass straight through.
                     r_resp_valid <= 1'b1;
                     r_resp_hit   <= 1'b1;
                     r_paddr      <= vaddr[PPN_W+OFF_W-1:0];
                  end else if (w_hit) begin
                     r_resp_valid <= 1'b1;
                     r_resp_hit   <= 1'b1;
                     r_paddr      <= {r_ent[w_hit_idx].ppn, w_req_off};
                     for (int i = 0; i < N; i++) begin
                        if (i == int'(w_hit_idx)) begin
                           r_ent[i].age <= '0;
                        end else if (r_ent[i].valid && (r_ent[i].age != c_AGE_MAX)) begin
                           r_ent[i].age <= r_ent[i].age + AGE_W'(1);
                        end
                     end
                  end else begin
                     r_lat_vpn  <= w_req_vpn;
                     r_lat_off  <= w_req_off;
                     r_lat_asid <= asid;
                  end
               end
            end
            WALK_WAIT: begin
               if (ptw_resp_valid) begin
                  r_resp_valid <= 1'b1;
                  if (ptw_resp_fault) begin
                     r_resp_fault <= 1'b1;
                  end else begin
                     r_paddr <= {ptw_resp_ppn, r_lat_off};
                     for (int i = 0; i < N; i++) begin
                        if (i != int'(w_victim) && r_ent[i].valid &&
                            (r_ent[i].age != c_AGE_MAX)) begin
                           r_ent[i].age <= r_ent[i].age + AGE_W'(1);
                        end
                     end
                     r_ent[w_victim].valid <= 1'b1;
                     r_ent[w_victim].glb   <= ptw_resp_global;
                     r_ent[w_victim].asid  <= r_lat_asid;
                     r_ent[w_victim].vpn   <= r_lat_vpn;
                     r_ent[w_victim].ppn   <= ptw_resp_ppn;
                     r_ent[w_victim].age   <= '0;
                  end
               end
            end
            FLUSH: begin
               if (r_flush_all || (!r_ent[r_flush_idx].glb &&
                                   (r_ent[r_flush_idx].asid == r_flush_asid))) begin
                  r_ent[r_flush_idx].valid <= 1'b0;
               end
               r_flush_idx <= r_flush_idx + c_IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign resp_valid  = r_resp_valid;
   assign resp_hit    = r_resp_hit;
   assign resp_fault  = r_resp_fault;
   assign paddr       = r_paddr;
   assign ptw_req_vpn = r_lat_vpn;

`ifdef TLB_STATS_EN
   logic [31:0] r_stat_hits;
   logic [31:0] r_stat_misses;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stat_hits   <= '0;
         r_stat_misses <= '0;
      end else begin
         if (r_state == IDLE && w_accept && !mode && w_hit) begin
            r_stat_hits <= r_stat_hits + 32'd1;
         end
         if (r_state == IDLE && w_state_next == WALK_REQ) begin
            r_stat_misses <= r_stat_misses + 32'd1;
         end
      end
   end

   assign stat_hits   = r_stat_hits;
   assign stat_misses = r_stat_misses;
`endif

endmodule
`default_nettype wire
